rv32i_multicycle_cpu: RTL and testbench

- Multicycle RV32I integer core with one shared instruction/data memory port.
- Connects to a synchronous block-RAM/MMIO slave: registered read data, byte-masked writes.
- Fetches, decodes and executes one instruction at a time through a small state machine.
- Implements the base RV32I set except FENCE, ECALL and EBREAK, which execute as NOPs.

---
 rtl/rv32i_multicycle_cpu.sv | 192 +++++++++++++++++++
 tb/tb_rv32i_multicycle_cpu.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_cpu.sv
// Multicycle RV32I core: FETCH/DECODE/EXECUTE(/MEM/LOADWB) over one shared
// synchronous memory port with byte-masked writes. FENCE/ECALL/EBREAK act as NOPs.
module rv32i_multicycle_cpu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memReadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, LOADWB} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_mem_addr, r_mem_wdata;
  logic [31:0] r_regfile [0:31];
  logic [3:0]  r_mask;
  logic        r_mem_write;
  logic [1:0]  r_addr_lo;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1v, w_rs2v, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_alu_b, w_alu_res, w_eff, w_pc4, w_next_pc, w_wb_data, w_st_data, w_ld_data;
  logic [3:0]  w_st_mask;
  logic        w_wb_en, w_taken, w_alt;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_rs1v   = (w_rs1 == 5'd0) ? 32'd0 : r_regfile[w_rs1];
  assign w_rs2v   = (w_rs2 == 5'd0) ? 32'd0 : r_regfile[w_rs2];
  assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u  = {r_ir[31:12], 12'd0};
  assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_pc4    = r_pc + 32'd4;
  assign w_eff    = w_rs1v + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);

  // bit 30 selects SUB only for register ops, but selects SRA/SRAI for both forms
  assign w_alu_b  = (w_opcode == OP_REG) ? w_rs2v : w_imm_i;
  assign w_alt    = r_ir[30] & ((w_opcode == OP_REG) | (w_f3 == 3'b101));

  always_comb begin
    w_alu_res = 32'd0;
    case (w_f3)
      3'b000: w_alu_res = w_alt ? (w_rs1v - w_alu_b) : (w_rs1v + w_alu_b);
      3'b001: w_alu_res = w_rs1v << w_alu_b[4:0];
      3'b010: w_alu_res = {31'd0, $signed(w_rs1v) < $signed(w_alu_b)};
      3'b011: w_alu_res = {31'd0, w_rs1v < w_alu_b};
      3'b100: w_alu_res = w_rs1v ^ w_alu_b;
      3'b101: begin
        if (w_alt) w_alu_res = $signed(w_rs1v) >>> w_alu_b[4:0];
        else       w_alu_res = w_rs1v >> w_alu_b[4:0];
      end
      3'b110: w_alu_res = w_rs1v | w_alu_b;
      default: w_alu_res = w_rs1v & w_alu_b;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000: w_taken = (w_rs1v == w_rs2v);
      3'b001: w_taken = (w_rs1v != w_rs2v);
      3'b100: w_taken = ($signed(w_rs1v) <  $signed(w_rs2v));
      3'b101: w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
      3'b110: w_taken = (w_rs1v <  w_rs2v);
      3'b111: w_taken = (w_rs1v >= w_rs2v);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc4;
    w_wb_en   = 1'b0;
    w_wb_data = w_alu_res;
    case (w_opcode)
      OP_LUI:    begin w_wb_en = 1'b1; w_wb_data = w_imm_u; end
      OP_AUIPC:  begin w_wb_en = 1'b1; w_wb_data = r_pc + w_imm_u; end
      OP_JAL:    begin w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = r_pc + w_imm_j; end
      OP_JALR:   begin w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = (w_rs1v + w_imm_i) & ~32'd1; end
      OP_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OP_IMM, OP_REG: w_wb_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_st_data = w_rs2v;
    w_st_mask = 4'b1111;
    case (w_f3[1:0])
      2'b00: begin w_st_data = {4{w_rs2v[7:0]}};  w_st_mask = 4'b0001 << w_eff[1:0]; end
      2'b01: begin w_st_data = {2{w_rs2v[15:0]}}; w_st_mask = w_eff[1] ? 4'b1100 : 4'b0011; end
      default: ;
    endcase
  end

  assign w_ld_byte = memReadData[{r_addr_lo, 3'b000} +: 8];
  assign w_ld_half = r_addr_lo[1] ? memReadData[31:16] : memReadData[15:0];

  always_comb begin
    w_ld_data = memReadData;
    case (w_f3)
      3'b000: w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001: w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100: w_ld_data = {24'd0, w_ld_byte};
      3'b101: w_ld_data = {16'd0, w_ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_VECTOR;
      r_ir        <= 32'd0;
      r_mem_addr  <= RESET_VECTOR;
      r_mem_wdata <= 32'd0;
      r_mask      <= 4'd0;
      r_mem_write <= 1'b0;
      r_addr_lo   <= 2'd0;
      for (int i = 0; i < 32; i++) r_regfile[i] <= 32'd0;
    end else begin
      unique case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          r_ir    <= memReadData;
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          if (w_opcode == OP_LOAD || w_opcode == OP_STORE) begin
            r_addr_lo  <= w_eff[1:0];
            r_mem_addr <= {w_eff[31:2], 2'b00};
            if (w_opcode == OP_STORE) begin
              r_mem_write <= 1'b1;
              r_mask      <= w_st_mask;
              r_mem_wdata <= w_st_data;
            end
            r_state <= MEM;
          end else begin
            if (w_wb_en && w_rd != 5'd0) r_regfile[w_rd] <= w_wb_data;
            r_pc       <= w_next_pc;
            r_mem_addr <= w_next_pc;
            r_state    <= FETCH;
          end
        end
        MEM: begin
          r_mem_write <= 1'b0;
          r_mask      <= 4'd0;
          if (w_opcode == OP_STORE) begin
            r_pc       <= w_pc4;
            r_mem_addr <= w_pc4;
            r_state    <= FETCH;
          end else begin
            r_state <= LOADWB;
          end
        end
        LOADWB: begin
          if (w_rd != 5'd0) r_regfile[w_rd] <= w_ld_data;
          r_pc       <= w_pc4;
          r_mem_addr <= w_pc4;
          r_state    <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign memAddress   = r_mem_addr;
  assign memWriteData = r_mem_wdata;
  assign byteMask     = r_mask;
  assign memWrite     = r_mem_write;
endmodule

// File: tb/tb_rv32i_multicycle_cpu.sv
// Bench for rv32i_multicycle_cpu: directed programs plus a random program,
// each instruction checked against an instruction-level reference model.
module tb_rv32i_multicycle_cpu;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memReadData, memAddress, memWriteData;
  logic [3:0]  byteMask;
  logic        memWrite;

  always #5 clk = ~clk;

  rv32i_multicycle_cpu #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .memReadData(memReadData), .memAddress(memAddress),
    .memWriteData(memWriteData), .byteMask(byteMask), .memWrite(memWrite)
  );

  // synchronous memory: registered read, masked write; preload port used only under reset
  logic [31:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++)
        if (byteMask[b]) mem[memAddress[9:2]][8*b +: 8] <= memWriteData[8*b +: 8];
    end else if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
    memReadData <= mem[memAddress[9:2]];
  end

  logic [31:0] m_mem [0:255];
  logic [31:0] m_x [0:31];
  logic [31:0] m_pc;
  int n_err = 0, n_checks = 0;
  logic [3:0]  cap_mask;
  logic [31:0] cap_data, cap_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_REG};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  // branch/jump offsets are given in halfwords (byte offset / 2)
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    ld_idx = idx; ld_data = d; ld_en = 1'b1;
    m_mem[idx] = d;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic hold_reset();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic release_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s x%0d", tag, i), dut.r_regfile[i], m_x[i]);
  endtask

  // Reference: execute the instruction at m_pc architecturally, then run the DUT
  // for the instruction's cycle count and compare PC, destination and memory.
  task automatic step(input string tag);
    logic [31:0] ins, a, b, bb, res, addr, npc, w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [3:0]  emask;
    logic        wr, st, alt, tk;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    int lat, pulses, sh, imm_i, imm_s, imm_b, imm_j, hoff;
    ins = m_mem[m_pc[9:2]];
    op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
    a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
    imm_i = int'($signed(ins[31:20]));
    imm_s = int'($signed({ins[31:25], ins[11:7]}));
    imm_b = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    npc = m_pc + 32'd4; wr = 1'b0; st = 1'b0; res = 32'd0; lat = 3; addr = 32'd0; emask = 4'd0;
    case (op)
      OPC_LUI:   begin res = {ins[31:12], 12'h000}; wr = 1'b1; end
      OPC_AUIPC: begin res = m_pc + {ins[31:12], 12'h000}; wr = 1'b1; end
      7'b1101111: begin res = m_pc + 32'd4; npc = m_pc + imm_j; wr = 1'b1; end
      OPC_JALR:  begin res = m_pc + 32'd4; npc = (a + imm_i) & ~32'd1; wr = 1'b1; end
      7'b1100011: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + imm_b;
      end
      OPC_LOAD: begin
        addr = a + imm_i; w = m_mem[addr[9:2]]; lat = 5; wr = 1'b1;
        hoff = addr[1] ? 16 : 0;
        case (f3)
          3'd0: begin s8 = w[8*addr[1:0] +: 8]; res = 32'(s8); end
          3'd1: begin s16 = w[hoff +: 16]; res = 32'(s16); end
          3'd4: res = {24'd0, w[8*addr[1:0] +: 8]};
          3'd5: res = {16'd0, w[hoff +: 16]};
          default: res = w;
        endcase
      end
      7'b0100011: begin
        addr = a + imm_s; lat = 4; st = 1'b1;
        hoff = addr[1] ? 16 : 0;
        case (f3)
          3'd0: begin m_mem[addr[9:2]][8*addr[1:0] +: 8] = b[7:0]; emask = 4'b0001 << addr[1:0]; end
          3'd1: begin m_mem[addr[9:2]][hoff +: 16] = b[15:0]; emask = addr[1] ? 4'b1100 : 4'b0011; end
          default: begin m_mem[addr[9:2]] = b; emask = 4'b1111; end
        endcase
      end
      OPC_IMM, OPC_REG: begin
        wr = 1'b1;
        bb = (op == OPC_REG) ? b : imm_i;
        alt = ins[30] && (op == OPC_REG || f3 == 3'd5);
        sh = int'(bb[4:0]);
        case (f3)
          3'd0: res = alt ? a - bb : a + bb;
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
          3'd3: res = (a < bb) ? 32'd1 : 32'd0;
          3'd4: res = a ^ bb;
          3'd5: begin
            res = a >> sh;
            if (alt && a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
          end
          3'd6: res = a | bb;
          default: res = a & bb;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = npc;

    pulses = 0;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (memWrite) begin
        pulses++; cap_mask = byteMask; cap_data = memWriteData; cap_addr = memAddress;
      end
    end
    check({tag, " pc"}, dut.r_pc, m_pc);
    if (wr) check({tag, " rd"}, dut.r_regfile[rd], m_x[rd]);
    check({tag, " write pulses"}, pulses, st ? 32'd1 : 32'd0);
    if (st) begin
      check({tag, " mask"}, {28'd0, cap_mask}, {28'd0, emask});
      check({tag, " mem"}, mem[addr[9:2]], m_mem[addr[9:2]]);
    end
  endtask

  function automatic logic [31:0] gen_rand();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] r;
    rd = 5'($urandom_range(0, 15)); rs1 = 5'($urandom_range(0, 15)); rs2 = 5'($urandom_range(0, 15));
    r = $urandom; f3 = r[14:12];
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        imm = r[31:20];
        if (f3 == 3'd1) imm = {7'd0, r[24:20]};
        else if (f3 == 3'd5) imm = {1'b0, r[10], 5'd0, r[24:20]};
        return enc_i(imm, rs1, f3, rd, OPC_IMM);
      end
      3, 4: return enc_r((f3 == 3'd0 || f3 == 3'd5) ? {1'b0, r[5], 5'd0} : 7'd0, rs2, rs1, f3, rd);
      5: return enc_u(r[31:12], rd, r[0] ? OPC_LUI : OPC_AUIPC);
      6: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
        return enc_i(12'h200 + {3'd0, r[28:20]}, 5'd0, f3, rd, OPC_LOAD);
      end
      7: return enc_s(12'h200 + {3'd0, r[28:20]}, rs2, 5'd0, (f3[1:0] == 2'd3) ? 3'd2 : {1'b0, f3[1:0]});
      8: return enc_b(12'd4, rs2, rs1, (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3);
      default: return enc_j(r[0] ? 20'd2 : 20'd4, rd);
    endcase
  endfunction

  initial begin
    int pulses, guard;
    reset = 1'b0; ld_en = 1'b0; ld_idx = 8'd0; ld_data = 32'd0;
    for (int i = 0; i < 256; i++) poke(8'(i), 32'd0);
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clk);
    check("reset pc", dut.r_pc, 32'd0);
    check("reset ir", dut.r_ir, 32'd0);
    check("reset memAddress", memAddress, 32'd0);
    check("reset byteMask", {28'd0, byteMask}, 32'd0);
    check("reset memWrite", {31'd0, memWrite}, 32'd0);
    check_all_regs("reset");

    // lw from a preloaded word
    poke(8'd0, enc_i(12'd4, 5'd0, 3'b010, 5'd1, OPC_LOAD));
    poke(8'd1, 32'hDEAD_BEEF);
    release_reset();
    step("lw");
    check("lw x1 value", dut.r_regfile[1], 32'hDEAD_BEEF);
    check("lw pc", dut.r_pc, 32'h4);

    // sub-word loads around a data word sitting at address 8
    hold_reset();
    poke(8'd0, enc_i(12'd8, 5'd0, 3'b000, 5'd1, OPC_LOAD));
    poke(8'd1, enc_j(20'd6, 5'd0));
    poke(8'd2, 32'h0000_80F0);
    poke(8'd4, enc_i(12'd8, 5'd0, 3'b100, 5'd2, OPC_LOAD));
    poke(8'd5, enc_i(12'd8, 5'd0, 3'b001, 5'd3, OPC_LOAD));
    poke(8'd6, enc_i(12'd10, 5'd0, 3'b101, 5'd4, OPC_LOAD));
    release_reset();
    for (int i = 0; i < 5; i++) step($sformatf("load seq %0d", i));
    check("lb value", dut.r_regfile[1], 32'hFFFF_FFF0);
    check("lbu value", dut.r_regfile[2], 32'h0000_00F0);
    check("lh value", dut.r_regfile[3], 32'hFFFF_80F0);
    check("lhu value", dut.r_regfile[4], 32'h0000_0000);

    // stores
    hold_reset();
    poke(8'd0, enc_u(20'h12345, 5'd2, OPC_LUI));
    poke(8'd1, enc_i(12'h678, 5'd2, 3'b000, 5'd2, OPC_IMM));
    poke(8'd2, enc_s(12'd5, 5'd2, 5'd0, 3'b000));
    poke(8'd3, enc_s(12'h204, 5'd2, 5'd0, 3'b010));
    poke(8'd4, enc_s(12'h20A, 5'd2, 5'd0, 3'b001));
    release_reset();
    step("lui"); step("addi");
    check("x2 value", dut.r_regfile[2], 32'h1234_5678);
    step("sb");
    check("sb mask", {28'd0, cap_mask}, 32'h2);
    check("sb data", cap_data, 32'h7878_7878);
    check("sb address", cap_addr, 32'h4);
    step("sw");
    check("sw mask", {28'd0, cap_mask}, 32'hF);
    check("sw word", mem[8'h81], 32'h1234_5678);
    step("sh");
    check("sh mask", {28'd0, cap_mask}, 32'hC);
    check("sh data", cap_data, 32'h5678_5678);

    // ALU and x0
    hold_reset();
    poke(8'd0, enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, OPC_IMM));
    poke(8'd1, enc_r(7'd0, 5'd3, 5'd0, 3'b011, 5'd4));
    poke(8'd2, enc_r(7'd0, 5'd3, 5'd0, 3'b010, 5'd5));
    poke(8'd3, enc_i(12'h404, 5'd3, 3'b101, 5'd6, OPC_IMM));
    poke(8'd4, enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPC_IMM));
    release_reset();
    for (int i = 0; i < 5; i++) step($sformatf("alu %0d", i));
    check("addi -1", dut.r_regfile[3], 32'hFFFF_FFFF);
    check("sltu", dut.r_regfile[4], 32'd1);
    check("slt", dut.r_regfile[5], 32'd0);
    check("srai", dut.r_regfile[6], 32'hFFFF_FFFF);
    check("x0 stays 0", dut.r_regfile[0], 32'd0);

    // control flow
    hold_reset();
    poke(8'd0, enc_j(20'd16, 5'd0));
    poke(8'h08, enc_b(12'd4, 5'd0, 5'd0, 3'b000));
    poke(8'h0A, enc_b(12'd4, 5'd0, 5'd0, 3'b001));
    poke(8'h0B, enc_j(20'd10, 5'd0));
    poke(8'h10, enc_j(20'd8, 5'd1));
    poke(8'h14, enc_i(12'd1, 5'd1, 3'b000, 5'd0, OPC_JALR));
    release_reset();
    step("jal to 0x20");
    step("beq");  check("beq target", dut.r_pc, 32'h28);
    step("bne");  check("bne fallthrough", dut.r_pc, 32'h2C);
    step("jal to 0x40");
    step("jal link"); check("jal pc", dut.r_pc, 32'h50); check("jal x1", dut.r_regfile[1], 32'h44);
    step("jalr"); check("jalr pc", dut.r_pc, 32'h44);

    // reset during a store's EXECUTE
    hold_reset();
    poke(8'd0, enc_i(12'h055, 5'd0, 3'b000, 5'd7, OPC_IMM));
    poke(8'd1, enc_s(12'h210, 5'd7, 5'd0, 3'b010));
    poke(8'h84, 32'hA5A5_A5A5);
    release_reset();
    step("pre-abort addi");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("async reset pc", dut.r_pc, 32'd0);
    check("async reset memAddress", memAddress, 32'd0);
    pulses = (memWrite === 1'b1) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (memWrite !== 1'b0) pulses++;
    end
    check("abort write pulses", pulses, 32'd0);
    check("abort mem untouched", mem[8'h84], 32'hA5A5_A5A5);
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    check_all_regs("abort");

    // random program against the reference model
    for (int i = 128; i < 256; i++) poke(8'(i), $urandom);
    for (int i = 0; i < 60; i++) poke(8'(i), gen_rand());
    for (int i = 60; i < 64; i++) poke(8'(i), 32'd0);
    release_reset();
    guard = 0;
    while (m_pc < 32'd240 && guard < 200) begin
      step($sformatf("rand %0d @%h", guard, m_pc));
      guard++;
    end
    check_all_regs("rand end");
    for (int i = 128; i < 256; i++) check($sformatf("rand mem[%0d]", i), mem[i], m_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
